// File: rtl/discriminated_capture_buffer_if.sv
// Output stream of the capture buffer: one word per out_valid && out_ready.
interface discriminated_capture_buffer_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/discriminated_capture_buffer.sv
// Single-channel capture memory behind the sample discriminator. Kept sample
// batches go to a data RAM, timestamps to a timestamp RAM; after capture stops
// both are drained as header, timestamps (oldest first), then data.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_data/out_last/out_valid hold until that transfer.
module discriminated_capture_buffer #(
    parameter int DATA_WIDTH   = 256,
    parameter int TSTAMP_WIDTH = 64,
    parameter int DATA_DEPTH   = 1024,
    parameter int TSTAMP_DEPTH = 256
) (
    input  logic                    adc_clk,
    input  logic                    adc_reset,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_in_valid,
    input  logic [TSTAMP_WIDTH-1:0] tstamp_in,
    input  logic                    tstamp_in_valid,
    input  logic                    capture_start,
    input  logic                    capture_stop,
    input  logic                    readout_start,
    discriminated_capture_buffer_if.master out_if,
    output logic                    capturing,
    output logic                    done,
    output logic                    overflow,
    output logic [2:0]              dbg_state_o
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int TAW = $clog2(TSTAMP_DEPTH);
    localparam int DCW = DAW + 1;
    localparam int TCW = TAW + 1;
    // Readout index spans header-less item list ts_count + data_count.
    localparam int IW  = ((DCW > TCW) ? DCW : TCW) + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CAPTURE   = 3'd1,
        S_HOLD      = 3'd2,
        S_READ_HDR  = 3'd3,
        S_READ_TS   = 3'd4,
        S_READ_DATA = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DCW-1:0]          data_count_q, data_count_d;
    logic [TCW-1:0]          ts_count_q, ts_count_d;
    logic                    overflow_q, overflow_d;
    logic [IW-1:0]           rd_idx_q, rd_idx_d;
    logic [IW-1:0]           out_left_q, out_left_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [DATA_WIDTH-1:0]   fifo0_q, fifo0_d, fifo1_q, fifo1_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_sel_ts_q, rd_sel_ts_d;
    logic [DATA_WIDTH-1:0]   data_rd_q;
    logic [TSTAMP_WIDTH-1:0] ts_rd_q;

    logic [DATA_WIDTH-1:0]   data_ram [DATA_DEPTH];
    logic [TSTAMP_WIDTH-1:0] ts_ram   [TSTAMP_DEPTH];

    logic                  arm, in_cap, reading, data_full, ts_full;
    logic                  data_we, ts_we, data_drop, ts_drop;
    logic                  hdr_push, push, pop, out_valid, issue, issue_ts;
    logic [2:0]            occ;
    logic [IW-1:0]         total;
    logic [DATA_WIDTH-1:0] header_word, push_word;

    // Decode of capture writes, readout issue and skid occupancy.
    always_comb begin
        arm       = capture_start && (state_q == S_IDLE || state_q == S_HOLD);
        in_cap    = (state_q == S_CAPTURE);
        reading   = (state_q == S_READ_HDR) || (state_q == S_READ_TS) || (state_q == S_READ_DATA);
        data_full = (data_count_q == DCW'(DATA_DEPTH));
        ts_full   = (ts_count_q == TCW'(TSTAMP_DEPTH));
        data_we   = in_cap && data_in_valid && !data_full;
        data_drop = in_cap && data_in_valid && data_full;
        ts_we     = in_cap && tstamp_in_valid && !ts_full;
        ts_drop   = in_cap && tstamp_in_valid && ts_full;
        hdr_push  = (state_q == S_HOLD) && readout_start && !capture_start;
        total     = IW'(ts_count_q) + IW'(data_count_q);
        out_valid = (fifo_cnt_q != 2'd0);
        pop       = out_valid && out_if.out_ready;
        push      = hdr_push || rd_valid_q;
        // Words held or in flight after this edge; a new read may only be
        // issued while that stays below the two skid entries.
        occ       = 3'(fifo_cnt_q) + 3'(rd_valid_q) + 3'(hdr_push) - 3'(pop);
        issue     = (hdr_push || reading) && (rd_idx_q < total) && (occ < 3'd2);
        issue_ts  = (rd_idx_q < IW'(ts_count_q));
        header_word        = '0;
        header_word[63:32] = 32'(ts_count_q);
        header_word[31:0]  = 32'(data_count_q);
        push_word = hdr_push ? header_word
                  : (rd_sel_ts_q ? DATA_WIDTH'(ts_rd_q) : data_rd_q);
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (capture_start) state_d = S_CAPTURE;
            S_CAPTURE:   if (capture_stop || data_full || ts_full) state_d = S_HOLD;
            S_HOLD: begin
                if (capture_start)      state_d = S_CAPTURE;
                else if (readout_start) state_d = S_READ_HDR;
            end
            S_READ_HDR: begin
                if (pop) begin
                    if (out_left_q == '0)       state_d = S_IDLE;
                    else if (ts_count_q != '0)  state_d = S_READ_TS;
                    else                        state_d = S_READ_DATA;
                end
            end
            S_READ_TS: begin
                if (pop) begin
                    if (out_left_q == '0)                     state_d = S_IDLE;
                    else if (out_left_q == IW'(data_count_q)) state_d = S_READ_DATA;
                end
            end
            S_READ_DATA: if (pop && out_left_q == '0) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Capture counters, sticky overflow and readout cursors.
    always_comb begin
        data_count_d = data_count_q;
        ts_count_d   = ts_count_q;
        overflow_d   = overflow_q;
        rd_idx_d     = rd_idx_q;
        out_left_d   = out_left_q;
        rd_valid_d   = issue;
        rd_sel_ts_d  = issue ? issue_ts : rd_sel_ts_q;
        if (arm) begin
            data_count_d = '0;
            ts_count_d   = '0;
            overflow_d   = 1'b0;
            rd_idx_d     = '0;
        end else begin
            if (data_we) data_count_d = data_count_q + DCW'(1);
            if (ts_we)   ts_count_d   = ts_count_q + TCW'(1);
            if (data_drop || ts_drop) overflow_d = 1'b1;
            if (issue)   rd_idx_d     = rd_idx_q + IW'(1);
        end
        if (hdr_push)
            out_left_d = total;
        else if (pop && out_left_q != '0)
            out_left_d = out_left_q - IW'(1);
    end

    // Two-entry output skid; entry 0 is what the stream presents.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) fifo0_d = push_word;
                else                    fifo1_d = push_word;
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo0_d    = fifo1_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    fifo0_d = push_word;
                end else begin
                    fifo0_d = fifo1_q;
                    fifo1_d = push_word;
                end
            end
            default: ;
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            state_q      <= S_IDLE;
            data_count_q <= '0;
            ts_count_q   <= '0;
            overflow_q   <= 1'b0;
            rd_idx_q     <= '0;
            out_left_q   <= '0;
            fifo_cnt_q   <= '0;
            fifo0_q      <= '0;
            fifo1_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_sel_ts_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_count_q <= data_count_d;
            ts_count_q   <= ts_count_d;
            overflow_q   <= overflow_d;
            rd_idx_q     <= rd_idx_d;
            out_left_q   <= out_left_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo0_q      <= fifo0_d;
            fifo1_q      <= fifo1_d;
            rd_valid_q   <= rd_valid_d;
            rd_sel_ts_q  <= rd_sel_ts_d;
        end
    end

    // Data RAM: write during capture, registered read during readout.
    always_ff @(posedge adc_clk) begin
        if (data_we) data_ram[DAW'(data_count_q)] <= data_in;
        if (issue && !issue_ts) data_rd_q <= data_ram[DAW'(rd_idx_q - IW'(ts_count_q))];
    end

    // Timestamp RAM: write during capture, registered read during readout.
    always_ff @(posedge adc_clk) begin
        if (ts_we) ts_ram[TAW'(ts_count_q)] <= tstamp_in;
        if (issue && issue_ts) ts_rd_q <= ts_ram[TAW'(rd_idx_q)];
    end

    assign out_if.out_data  = fifo0_q;
    assign out_if.out_valid = out_valid;
    assign out_if.out_last  = out_valid && (out_left_q == '0);
    assign capturing        = (state_q == S_CAPTURE);
    assign done             = (state_q == S_HOLD);
    assign overflow         = overflow_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_discriminated_capture_buffer.sv
// Bench for discriminated_capture_buffer: queue-based reference of what was
// captured, scoreboard of expected readout words, independent output monitor.
module tb_discriminated_capture_buffer;
    localparam int DW = 256;
    localparam int TW = 64;
    localparam int DD = 16;
    localparam int TD = 4;

    logic          adc_clk = 1'b0;
    logic          adc_reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [TW-1:0] tstamp_in = '0;
    logic          tstamp_in_valid = 1'b0;
    logic          capture_start = 1'b0;
    logic          capture_stop = 1'b0;
    logic          readout_start = 1'b0;
    logic          capturing, done, overflow;
    logic [2:0]    dbg_state_o;

    discriminated_capture_buffer_if #(.DATA_WIDTH(DW)) out_if ();

    discriminated_capture_buffer #(
        .DATA_WIDTH(DW), .TSTAMP_WIDTH(TW), .DATA_DEPTH(DD), .TSTAMP_DEPTH(TD)
    ) dut (
        .adc_clk(adc_clk), .adc_reset(adc_reset),
        .data_in(data_in), .data_in_valid(data_in_valid),
        .tstamp_in(tstamp_in), .tstamp_in_valid(tstamp_in_valid),
        .capture_start(capture_start), .capture_stop(capture_stop),
        .readout_start(readout_start), .out_if(out_if),
        .capturing(capturing), .done(done), .overflow(overflow),
        .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 adc_clk = ~adc_clk;

    // Counters and scoreboard
    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [DW:0] exp_q[$];   // {last, word}

    // Reference model of captured contents
    bit            m_cap = 1'b0;
    bit            m_ovf = 1'b0;
    logic [DW-1:0] m_data[$];
    logic [TW-1:0] m_ts[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    // One input cycle, applied to both the model and the DUT.
    task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic tv,
                         input logic [TW-1:0] t, input logic stop);
        bit full_before;
        if (m_cap) begin
            full_before = (m_data.size() == DD) || (m_ts.size() == TD);
            if (dv) begin
                if (m_data.size() < DD) m_data.push_back(d);
                else m_ovf = 1'b1;
            end
            if (tv) begin
                if (m_ts.size() < TD) m_ts.push_back(t);
                else m_ovf = 1'b1;
            end
            if (stop || full_before) m_cap = 1'b0;
        end
        data_in = d; data_in_valid = dv; tstamp_in = t; tstamp_in_valid = tv;
        capture_stop = stop;
        tick();
        data_in_valid = 1'b0; tstamp_in_valid = 1'b0; capture_stop = 1'b0;
    endtask

    task automatic start_cap();
        m_data.delete(); m_ts.delete(); m_ovf = 1'b0; m_cap = 1'b1;
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
        chk("capturing after start", capturing, 1'b1);
    endtask

    task automatic check_hold();
        chk("done in hold", done, 1'b1);
        chk("capturing in hold", capturing, 1'b0);
        chk("overflow", overflow, m_ovf);
    endtask

    // Push expected readout, start it, run with given ready percentage.
    // abort_after >= 0 resets the DUT after that many readout cycles.
    task automatic readout(input int ready_pct, input int abort_after);
        logic [DW-1:0] hdr;
        int total, cyc;
        bit aborted;
        total = m_ts.size() + m_data.size();
        hdr = '0;
        hdr[63:32] = 32'(m_ts.size());
        hdr[31:0]  = 32'(m_data.size());
        exp_q.push_back({total == 0, hdr});
        for (int i = 0; i < m_ts.size(); i++)
            exp_q.push_back({(i == m_ts.size() - 1) && (m_data.size() == 0), DW'(m_ts[i])});
        for (int i = 0; i < m_data.size(); i++)
            exp_q.push_back({i == m_data.size() - 1, m_data[i]});
        readout_start = 1'b1;
        tick();
        readout_start = 1'b0;
        chk("header valid latency", out_if.out_valid, 1'b1);
        cyc = 0;
        aborted = 1'b0;
        while (exp_q.size() != 0 && cyc < 400) begin
            if (cyc == abort_after) begin
                aborted = 1'b1;
                break;
            end
            out_if.out_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
            cyc++;
        end
        out_if.out_ready = 1'b0;
        if (aborted) begin
            adc_reset = 1'b1;
            tick();
            chk("abort out_valid", out_if.out_valid, 1'b0);
            chk("abort state idle", dbg_state_o, 3'd0);
            adc_reset = 1'b0;
            exp_q.delete();
            m_cap = 1'b0;
        end else if (exp_q.size() != 0) begin
            chk("readout timeout words left", exp_q.size(), 0);
            exp_q.delete();
        end else begin
            if (ready_pct >= 100) chk("no-bubble cycles", cyc, total + 1);
            tick();
            chk("idle after readout", dbg_state_o, 3'd0);
            chk("out_valid after readout", out_if.out_valid, 1'b0);
        end
    endtask

    // Monitor: pops expected words on each handshake, checks stall stability.
    logic          held_valid = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;
    always @(negedge adc_clk) begin
        logic [DW:0] e;
        if (adc_reset) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                chk("stall valid held", out_if.out_valid, 1'b1);
                chk("stall data held", out_if.out_data, held_data);
                chk("stall last held", out_if.out_last, held_last);
            end
            if (out_if.out_valid && out_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected word", out_if.out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_if.out_data, e[DW-1:0]);
                    chk("out_last", out_if.out_last, e[DW]);
                end
            end
            held_valid = out_if.out_valid && !out_if.out_ready;
            held_data  = out_if.out_data;
            held_last  = out_if.out_last;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        out_if.out_ready = 1'b0;
        repeat (3) tick();
        adc_reset = 1'b0;
        chk("reset out_valid", out_if.out_valid, 1'b0);
        chk("reset out_last", out_if.out_last, 1'b0);
        chk("reset out_data", out_if.out_data, '0);
        chk("reset capturing", capturing, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        chk("reset state", dbg_state_o, 3'd0);

        // readout_start and inputs outside capture are ignored
        readout_start = 1'b1;
        tick();
        readout_start = 1'b0;
        chk("readout in idle ignored", out_if.out_valid, 1'b0);
        cycle(1'b1, DW'(32'hDEAD), 1'b1, TW'(32'hBEEF), 1'b0);

        // Basic capture and full-speed readout
        start_cap();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, DW'(i + 1), (i < 2), (i == 0) ? TW'(8'hA0) : TW'(8'hB0), 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check_hold();
        readout(100, -1);

        // Data RAM fills: 20 batches, no stop
        start_cap();
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(i + 1), 1'b0, '0, 1'b0);
        check_hold();
        readout(100, -1);

        // Timestamp RAM fills: 5 timestamps with 3 batches
        start_cap();
        for (int i = 0; i < 5; i++) cycle((i < 3), DW'(i + 8'h40), 1'b1, TW'(i + 12'h100), 1'b0);
        check_hold();
        readout(100, -1);

        // Empty capture; inputs in hold are ignored
        start_cap();
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b1, rand_word(), 1'b1, TW'($urandom), 1'b0);
        check_hold();
        readout(100, -1);

        // 3 ts + 10 data with 30% ready
        start_cap();
        for (int i = 0; i < 10; i++) cycle(1'b1, rand_word(), (i < 3), {$urandom, $urandom}, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check_hold();
        readout(30, -1);

        // Random sessions
        for (int r = 0; r < 4; r++) begin
            start_cap();
            n = $urandom_range(3, 24);
            for (int i = 0; i < n; i++)
                cycle($urandom_range(0, 1), rand_word(), ($urandom_range(0, 3) == 0),
                      {$urandom, $urandom}, (i == n - 1));
            check_hold();
            readout((r % 2 == 0) ? 100 : 30, -1);
        end

        // Reset mid READ_DATA, then a fresh capture
        start_cap();
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_word(), (i == 0), {$urandom, $urandom}, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check_hold();
        readout(100, 4);
        chk("overflow after abort", overflow, 1'b0);
        start_cap();
        cycle(1'b1, DW'(16'h1111), 1'b0, '0, 1'b0);
        cycle(1'b1, DW'(16'h2222), 1'b0, '0, 1'b1);
        check_hold();
        readout(100, -1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/discriminated_capture_buffer.md
Name: discriminated_capture_buffer

Overview:
- Single-channel capture memory that sits directly downstream of the sample discriminator.
- Stores the discriminator's kept sample batches in a data RAM and its timestamp words in a separate timestamp RAM.
- After capture stops, drains both to the PS over one AXI-stream-style output: header word, then timestamps, then data.
- One instance per rx channel; all logic runs in the ADC clock domain.

Parameters:
DATA_WIDTH, 256, width of one parallel sample batch (rx_pkg::DATA_WIDTH)
TSTAMP_WIDTH, 64, timestamp word width (buffer_pkg::TSTAMP_WIDTH); must be <= DATA_WIDTH
DATA_DEPTH, 1024, data RAM depth in batches; power of 2
TSTAMP_DEPTH, 256, timestamp RAM depth in words; power of 2

Ports:
adc_clk  in  1  clock; the only clock
adc_reset  in  1  synchronous, active-high reset
data_in  in  DATA_WIDTH  batch from discriminator
data_in_valid  in  1  batch qualifier; no backpressure
tstamp_in  in  TSTAMP_WIDTH  timestamp {time, sample_index} from discriminator
tstamp_in_valid  in  1  timestamp qualifier; no backpressure
capture_start  in  1  pulse; arms capture
capture_stop  in  1  pulse; ends capture
readout_start  in  1  pulse; begins drain
out_data  out  DATA_WIDTH  output word
out_valid  out  1  output handshake
out_ready  in  1  output handshake
out_last  out  1  marks final word of a readout
capturing  out  1  high while in CAPTURE
done  out  1  high while in HOLD
overflow  out  1  sticky; data or timestamp dropped because RAM full

Behaviour:
- Reset: state IDLE; out_valid, out_last, capturing, done, overflow = 0; write pointers and counts = 0; out_data = 0. Reset mid-capture or mid-readout aborts immediately. RAM contents are don't-care after reset.
- States: IDLE, CAPTURE, HOLD, READ_HDR, READ_TS, READ_DATA.
- IDLE -> CAPTURE on capture_start:
  - clears both write pointers and overflow;
  - capturing=1 from the next cycle.
- CAPTURE:
  - data_in_valid writes data_in at data_wptr, then data_wptr++;
  - tstamp_in_valid writes tstamp_in at ts_wptr, then ts_wptr++;
  - both writes may occur in the same cycle.
- CAPTURE exit to HOLD (next cycle) on any of:
  - capture_stop;
  - data RAM full (data_count == DATA_DEPTH);
  - timestamp RAM full (ts_count == TSTAMP_DEPTH).
- Full-boundary rules:
  - The write that reaches full is accepted.
  - Any valid input arriving while full, or in the cycle after full is reached, is dropped and sets overflow.
  - If capture_stop coincides with a valid input, that input is written.
- Counts are $clog2(DEPTH)+1 bits wide and never wrap.
- HOLD: done=1; data is retained. capture_start here returns to CAPTURE and discards the contents. readout_start -> READ_HDR.
- capture_start in any state other than IDLE/HOLD is ignored. readout_start outside HOLD is ignored.
- READ_HDR: out_data = {zero pad, ts_count[31:0] in bits [63:32], data_count[31:0] in bits [31:0]}. Counts are zero-extended to 32 bits.
- READ_TS: ts_count words, oldest first, each zero-extended to DATA_WIDTH.
- READ_DATA: data_count words, oldest first.
- Empty sections are skipped. If both counts are 0, the header carries out_last.
- out_last is asserted on the final word of the whole readout. After that word's handshake the block goes to IDLE.
- Output rules (AXI-stream):
  - once out_valid is high, out_data, out_last and out_valid are held until out_ready;
  - first header word valid 1 cycle after readout_start;
  - RAM read latency 1 cycle;
  - a 2-entry skid/prefetch is required so that with out_ready held high a word transfers every cycle, with no bubble between sections.
- Inputs arriving outside CAPTURE are ignored and do not set overflow.

Test Plan (DATA_DEPTH=16, TSTAMP_DEPTH=4):
- Start; 5 valid batches 0x1..0x5 and 2 timestamps 0xA0, 0xB0; stop; readout with out_ready=1 -> header ts=2/data=5, then 0xA0, 0xB0, 0x1..0x5 on consecutive cycles; out_last on 0x5; back to IDLE.
- 20 consecutive valid batches with no stop -> stops after 16; done=1; overflow=1; header data=16; last word is batch 16.
- 5 timestamps with 3 batches -> stops after the 4th timestamp; overflow=1; header ts=4/data=3.
- Start then immediate stop with no inputs; readout -> single header word of 0 with out_last=1.
- Random out_ready at 30% during readout of 3 ts + 10 data -> 14 words in order, each held stable while stalled, none lost or duplicated.
- adc_reset asserted mid-READ_DATA -> out_valid=0 the next cycle, state IDLE; a new capture of 2 batches then reads back header data=2.
